// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit signed divider.
// Holds the controller state encoding and the datapath sizing constants
// used by div32_seq and its add/subtract sub-module.
package div_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } divState_t;

endpackage

// File: rtl/addsub32.sv
// 32-bit add/subtract unit in the datapath's carry-select style.
// Ports:
//   a, b  : operands
//   sub   : 0 = a + b, 1 = a - b (b inverted, carry-in forced to 1)
//   sum   : result
//   cout  : carry out of bit 31 (for subtraction, 1 means no borrow)
//   ovf   : two's complement overflow
module addsub32
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] bEff;
   logic [15:0]      sumLo;
   logic             carryLo;
   logic [16:0]      hiIfCarry0;
   logic [16:0]      hiIfCarry1;

   // Low half ripples; the upper half is computed for both possible carries
   // and the low half's carry-out selects the right one.
   always_comb begin
      bEff                 = sub ? ~b : b;
      {carryLo, sumLo}     = {1'b0, a[15:0]} + {1'b0, bEff[15:0]} + {16'd0, sub};
      hiIfCarry0           = {1'b0, a[31:16]} + {1'b0, bEff[31:16]};
      hiIfCarry1           = {1'b0, a[31:16]} + {1'b0, bEff[31:16]} + 17'd1;
      {cout, sum[31:16]}   = carryLo ? hiIfCarry1 : hiIfCarry0;
      sum[15:0]            = sumLo;
      ovf                  = (a[31] == bEff[31]) && (sum[31] != a[31]);
   end

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit signed divider (restoring shift-subtract, one bit per clock).
// Ports:
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset
//   ctrl_DIV       : start pulse, operands sampled on the same edge
//   data_operandA  : dividend (two's complement)
//   data_operandB  : divisor (two's complement)
//   data_result    : quotient, truncated toward zero
//   data_remainder : remainder, sign follows the dividend
//   data_exception : divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY : one-cycle pulse when the outputs are updated
//   busy           : high from the cycle after start through the ready cycle
module div32_seq
   import div_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   divState_t        state;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] magB;
   logic [CNT_W-1:0] count;
   logic             signQ;
   logic             signR;
   logic             excFlag;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] shiftRem;
   logic [WIDTH-1:0] trialDiff;
   logic             trialCout;
   logic             addOvfUnused;

   // Operand magnitudes are treated as unsigned, so |-2^31| = 0x80000000 is
   // exact. The partial remainder stays below |B| <= 2^31, so the shifted
   // value always fits in 32 bits and the trial subtraction's carry-out acts
   // as the sign of the 33-bit difference (carry = 1 means T >= 0).
   always_comb begin
      absA     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
      absB     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
      shiftRem = {rem[WIDTH-2:0], quot[WIDTH-1]};
   end

   addsub32 u_trialSub (
      .a    (shiftRem),
      .b    (magB),
      .sub  (1'b1),
      .sum  (trialDiff),
      .cout (trialCout),
      .ovf  (addOvfUnused)
   );

   // Controller and datapath. quot/rem double as the pending result until the
   // DONE edge copies them to the output registers together with the ready
   // pulse, so the outputs only ever change on a ready cycle (or reset).
   // A start in any state restarts; a start in DONE still delivers the
   // finished result first.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         quot           <= '0;
         rem            <= '0;
         magB           <= '0;
         count          <= '0;
         signQ          <= 1'b0;
         signR          <= 1'b0;
         excFlag        <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            if (state == DONE) begin
               data_result    <= quot;
               data_remainder <= rem;
               data_exception <= excFlag;
               data_resultRDY <= 1'b1;
            end
            busy  <= 1'b1;
            signQ <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            signR <= data_operandA[WIDTH-1];
            magB  <= absB;
            count <= '0;
            if (data_operandB == '0) begin
               quot    <= '0;
               rem     <= data_operandA;
               excFlag <= 1'b1;
               state   <= DONE;
            end else begin
               quot    <= absA;
               rem     <= '0;
               excFlag <= 1'b0;
               state   <= RUN;
            end
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
               end
               RUN: begin
                  quot  <= {quot[WIDTH-2:0], trialCout};
                  rem   <= trialCout ? trialDiff : shiftRem;
                  count <= count + CNT_W'(1);
                  if (count == CNT_W'(ITER - 1)) begin
                     state <= FIX;
                  end
               end
               FIX: begin
                  quot  <= signQ ? (~quot + WIDTH'(1)) : quot;
                  rem   <= signR ? (~rem + WIDTH'(1)) : rem;
                  state <= DONE;
               end
               DONE: begin
                  data_result    <= quot;
                  data_remainder <= rem;
                  data_exception <= excFlag;
                  data_resultRDY <= 1'b1;
                  state          <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
